// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream bundle carrying a payload and a separate control word between pipeline stages.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 13
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and an optional 2-entry skid buffer.
// Also supports stall, flush-to-bubble and a saturating counter of entries discarded by flush.
module pipe_stage_reg #(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = 13,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
    parameter bit                SKID_EN  = 1'b1,
    parameter int                CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             stall_i,
    pipe_stage_reg_if.slave  up_if,
    pipe_stage_reg_if.master dn_if,
    output logic [1:0]       occupancy_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    // The state encoding is also the entry count, so occupancy is read straight from the flop.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [DATA_W-1:0] m_data_q,   m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q,   m_ctrl_d;
    logic [DATA_W-1:0] s_data_q,   s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q,   s_ctrl_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic act_s;
    logic m_valid_s;
    logic s_valid_s;
    logic in_ready_s;
    logic out_valid_s;
    logic xfer_in_s;
    logic xfer_out_s;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            sat_add = {CNT_W{1'b1}};
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    assign act_s       = ~flush_i & ~stall_i;
    assign m_valid_s   = (state_q != ST_EMPTY);
    assign s_valid_s   = (state_q == ST_FULL);
    assign out_valid_s = m_valid_s & act_s;

    // With the skid entry, in_ready comes only from flops so no combinational path runs back from out_ready.
    assign in_ready_s  = SKID_EN ? (act_s & ~s_valid_s)
                                 : (act_s & (~m_valid_s | dn_if.ready));

    assign xfer_in_s   = up_if.valid & in_ready_s;
    assign xfer_out_s  = out_valid_s & dn_if.ready;

    assign up_if.ready = in_ready_s;
    assign dn_if.valid = out_valid_s;
    assign dn_if.data  = m_data_q;
    assign dn_if.ctrl  = out_valid_s ? m_ctrl_q : NOP_CTRL;
    assign occupancy_o = state_q;
    assign drop_cnt_o  = drop_cnt_q;

    // Next-state and datapath selection; flush overrides every transfer.
    always_comb begin
        state_d    = state_q;
        m_data_d   = m_data_q;
        m_ctrl_d   = m_ctrl_q;
        s_data_d   = s_data_q;
        s_ctrl_d   = s_ctrl_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            state_d    = ST_EMPTY;
            m_data_d   = {DATA_W{1'b0}};
            m_ctrl_d   = NOP_CTRL;
            s_data_d   = {DATA_W{1'b0}};
            s_ctrl_d   = NOP_CTRL;
            drop_cnt_d = sat_add(drop_cnt_q, state_q);
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in_s) begin
                        state_d  = ST_ONE;
                        m_data_d = up_if.data;
                        m_ctrl_d = up_if.ctrl;
                    end else begin
                        state_d  = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (xfer_in_s && xfer_out_s) begin
                        state_d  = ST_ONE;
                        m_data_d = up_if.data;
                        m_ctrl_d = up_if.ctrl;
                    end else if (xfer_out_s) begin
                        state_d  = ST_EMPTY;
                    end else if (xfer_in_s) begin
                        state_d  = ST_FULL;
                        s_data_d = up_if.data;
                        s_ctrl_d = up_if.ctrl;
                    end else begin
                        state_d  = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // The skid entry moves into the main slot so ordering stays FIFO.
                    if (xfer_out_s) begin
                        state_d  = ST_ONE;
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                    end else begin
                        state_d  = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, entry storage and drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            m_data_q   <= {DATA_W{1'b0}};
            m_ctrl_q   <= NOP_CTRL;
            s_data_q   <= {DATA_W{1'b0}};
            s_ctrl_q   <= NOP_CTRL;
            drop_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            m_ctrl_q   <= m_ctrl_d;
            s_data_q   <= s_data_d;
            s_ctrl_q   <= s_ctrl_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid-buffered instance and one single-entry instance, with a
// queue scoreboard per instance plus directed checks of stall, flush, reset and saturation.
module tb_pipe_stage_reg;

    localparam int         DW   = 16;
    localparam int         CW   = 4;
    localparam int         CNTW = 8;
    localparam logic [3:0] NOP1 = 4'hA;
    localparam logic [3:0] NOP2 = 4'h5;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic flush1 = 1'b0;
    logic stall1 = 1'b0;
    logic flush2 = 1'b0;
    logic stall2 = 1'b0;
    logic [1:0]      occ1, occ2;
    logic [CNTW-1:0] drop1, drop2;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_drop;

    logic [19:0] sb1[$];
    logic [19:0] sb2[$];
    logic [19:0] e1, e2;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up1 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn1 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up2 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn2 ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP1), .SKID_EN(1'b1), .CNT_W(CNTW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush1), .stall_i(stall1),
        .up_if(up1), .dn_if(dn1), .occupancy_o(occ1), .drop_cnt_o(drop1));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP2), .SKID_EN(1'b0), .CNT_W(CNTW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush2), .stall_i(stall2),
        .up_if(up2), .dn_if(dn2), .occupancy_o(occ2), .drop_cnt_o(drop2));

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [15:0] d);
        up1.valid = v;
        up1.data  = d;
        up1.ctrl  = d[3:0] ^ 4'h3;
    endtask

    task automatic drive2(input logic v, input logic [15:0] d);
        up2.valid = v;
        up2.data  = d;
        up2.ctrl  = d[3:0] ^ 4'h6;
    endtask

    function automatic logic [19:0] pk1(input logic [15:0] d);
        return {d[3:0] ^ 4'h3, d};
    endfunction

    // Scoreboards: handshakes are stable at the falling edge and take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb1.delete();
            sb2.delete();
        end else begin
            if (dn1.valid && dn1.ready) begin
                check_eq("sb1_pending", 32'(sb1.size() > 0), 32'd1);
                if (sb1.size() > 0) begin
                    e1 = sb1.pop_front();
                    check_eq("sb1_entry", 32'({dn1.ctrl, dn1.data}), 32'(e1));
                end
            end
            if (flush1) sb1.delete();
            else if (up1.valid && up1.ready) sb1.push_back({up1.ctrl, up1.data});
            if (dn2.valid && dn2.ready) begin
                check_eq("sb2_pending", 32'(sb2.size() > 0), 32'd1);
                if (sb2.size() > 0) begin
                    e2 = sb2.pop_front();
                    check_eq("sb2_entry", 32'({dn2.ctrl, dn2.data}), 32'(e2));
                end
            end
            if (flush2) sb2.delete();
            else if (up2.valid && up2.ready) sb2.push_back({up2.ctrl, up2.data});
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive1(1'b0, 16'h0000);
        drive2(1'b0, 16'h0000);
        dn1.ready = 1'b0;
        dn2.ready = 1'b0;
        exp_drop  = 0;
        #12;
        check_eq("rst_occ",   32'(occ1), 32'd0);
        check_eq("rst_drop",  32'(drop1), 32'd0);
        check_eq("rst_valid", 32'(dn1.valid), 32'd0);
        check_eq("rst_data",  32'(dn1.data), 32'd0);
        check_eq("rst_ctrl",  32'(dn1.ctrl), 32'(NOP1));
        check_eq("rst_ctrl2", 32'(dn2.ctrl), 32'(NOP2));
        rst_n = 1'b1;
        tick();

        // Stream 1..8 back-to-back with one cycle of lag.
        dn1.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive1(1'b1, 16'(i));
            tick();
            check_eq("stream_valid", 32'(dn1.valid), 32'd1);
            check_eq("stream_data",  32'(dn1.data), 32'(i));
            check_eq("stream_ctrl",  32'(dn1.ctrl), 32'(4'(i) ^ 4'h3));
        end
        drive1(1'b0, 16'h0000);
        tick();
        check_eq("stream_end_valid", 32'(dn1.valid), 32'd0);
        check_eq("stream_end_occ",   32'(occ1), 32'd0);

        // Backpressure fills main then skid entry.
        dn1.ready = 1'b0;
        drive1(1'b1, 16'h00A1);
        tick();
        check_eq("bp_occ1",   32'(occ1), 32'd1);
        check_eq("bp_rdy1",   32'(up1.ready), 32'd1);
        drive1(1'b1, 16'h00B2);
        tick();
        check_eq("bp_occ2",   32'(occ1), 32'd2);
        check_eq("bp_rdy2",   32'(up1.ready), 32'd0);
        check_eq("bp_dataA",  32'(dn1.data), 32'h00A1);
        drive1(1'b1, 16'h00C3);
        tick();
        check_eq("bp_hold",   32'(occ1), 32'd2);
        dn1.ready = 1'b1;
        tick();
        check_eq("bp_outB",   32'(dn1.data), 32'h00B2);
        check_eq("bp_occB",   32'(occ1), 32'd1);
        check_eq("bp_rdyB",   32'(up1.ready), 32'd1);
        tick();
        drive1(1'b0, 16'h0000);
        check_eq("bp_outC",   32'(dn1.data), 32'h00C3);
        check_eq("bp_validC", 32'(dn1.valid), 32'd1);
        tick();
        check_eq("bp_done",   32'(dn1.valid), 32'd0);

        // Flush while FULL with a valid input present.
        dn1.ready = 1'b0;
        drive1(1'b1, 16'h0011);
        tick();
        drive1(1'b1, 16'h0022);
        tick();
        drive1(1'b1, 16'h0033);
        flush1 = 1'b1;
        #1;
        check_eq("fl_rdy",    32'(up1.ready), 32'd0);
        check_eq("fl_valid",  32'(dn1.valid), 32'd0);
        check_eq("fl_ctrl",   32'(dn1.ctrl), 32'(NOP1));
        tick();
        flush1 = 1'b0;
        drive1(1'b0, 16'h0000);
        exp_drop += 2;
        check_eq("fl_drop",   32'(drop1), 32'(exp_drop));
        check_eq("fl_occ",    32'(occ1), 32'd0);
        check_eq("fl_valid2", 32'(dn1.valid), 32'd0);
        check_eq("fl_data",   32'(dn1.data), 32'd0);
        check_eq("fl_ctrl2",  32'(dn1.ctrl), 32'(NOP1));

        // Stall while FULL with downstream ready.
        drive1(1'b1, 16'h0A0A);
        tick();
        drive1(1'b1, 16'h0B0B);
        tick();
        drive1(1'b0, 16'h0000);
        dn1.ready = 1'b1;
        stall1 = 1'b1;
        repeat (3) begin
            #1;
            check_eq("st_valid", 32'(dn1.valid), 32'd0);
            check_eq("st_rdy",   32'(up1.ready), 32'd0);
            check_eq("st_occ",   32'(occ1), 32'd2);
            check_eq("st_ctrl",  32'(dn1.ctrl), 32'(NOP1));
            check_eq("st_data",  32'(dn1.data), 32'h0A0A);
            tick();
        end
        stall1 = 1'b0;
        #1;
        check_eq("st_relA",   32'({dn1.valid, dn1.ctrl, dn1.data}), 32'({1'b1, pk1(16'h0A0A)}));
        tick();
        check_eq("st_relB",   32'({dn1.valid, dn1.ctrl, dn1.data}), 32'({1'b1, pk1(16'h0B0B)}));
        tick();
        check_eq("st_end",    32'(dn1.valid), 32'd0);

        // Asynchronous reset in the middle of a cycle while FULL.
        dn1.ready = 1'b0;
        drive1(1'b1, 16'h0101);
        tick();
        drive1(1'b1, 16'h0202);
        tick();
        drive1(1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        exp_drop = 0;
        check_eq("ar_occ",   32'(occ1), 32'd0);
        check_eq("ar_valid", 32'(dn1.valid), 32'd0);
        check_eq("ar_data",  32'(dn1.data), 32'd0);
        check_eq("ar_ctrl",  32'(dn1.ctrl), 32'(NOP1));
        check_eq("ar_drop",  32'(drop1), 32'(exp_drop));
        tick();
        rst_n = 1'b1;
        dn1.ready = 1'b1;
        drive1(1'b1, 16'h0D01);
        tick();
        check_eq("ar_rs1", 32'(dn1.data), 32'h0D01);
        drive1(1'b1, 16'h0D02);
        tick();
        check_eq("ar_rs2", 32'(dn1.data), 32'h0D02);
        drive1(1'b0, 16'h0000);
        tick();
        check_eq("ar_rs_end", 32'(dn1.valid), 32'd0);

        // Single-entry instance under random traffic.
        for (int i = 0; i < 200; i++) begin
            drive2(1'($urandom_range(0, 1)), 16'($urandom));
            dn2.ready = 1'($urandom_range(0, 1));
            #1;
            check_eq("sk0_occ_max", 32'(occ2 > 2'd1), 32'd0);
            check_eq("sk0_rdy", 32'(up2.ready), 32'((occ2 == 2'd0) | dn2.ready));
            tick();
        end
        drive2(1'b0, 16'h0000);
        dn2.ready = 1'b1;
        tick();
        tick();
        check_eq("sk0_drained", 32'(occ2), 32'd0);

        // Repeated flushes of a single held entry saturate the drop counter.
        dn2.ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive2(1'b1, 16'(i));
            tick();
            drive2(1'b0, 16'h0000);
            flush2 = 1'b1;
            tick();
            flush2 = 1'b0;
            if (i == 0 || i == 254 || i == 299) begin
                check_eq("sat_drop", 32'(drop2), 32'((i + 1 > 255) ? 255 : i + 1));
            end
        end
        check_eq("sat_occ", 32'(occ2), 32'd0);
        tick();
        check_eq("sb1_drained", 32'(sb1.size()), 32'd0);
        check_eq("sb2_drained", 32'(sb2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
